// File: rtl/divider_8b4b.sv
// Unsigned 8-bit by 4-bit restoring divider, one quotient bit per cycle.
// A zero divisor finishes on the acceptance edge with q=8'hFF, r=x[3:0] and dz=1.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). x and y are
// latched on that same edge. done is a one-cycle pulse that qualifies q/r/dz,
// and q/r/dz hold their value until the next completion.
module divider_8b4b (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [3:0] y,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       dz,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] dvd;
  logic [7:0] quo;
  logic [3:0] div;
  logic [3:0] rem;

  logic [4:0] part;
  logic       fits;
  logic [3:0] rem_next;
  logic [7:0] quo_next;

  // After a subtraction the partial remainder is below div, so it fits in 4 bits.
  always_comb begin
    part     = {rem, dvd[7]};
    fits     = (part >= {1'b0, div});
    rem_next = part[3:0];
    if (fits) rem_next = 4'(part - {1'b0, div});
    quo_next = {quo[6:0], fits};
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      dvd   <= 8'd0;
      div   <= 4'd0;
      rem   <= 4'd0;
      quo   <= 8'd0;
      q     <= 8'd0;
      r     <= 4'd0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          dvd <= {dvd[6:0], 1'b0};
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            q     <= quo_next;
            r     <= rem_next;
            dz    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          if (start) begin
            dvd <= x;
            div <= y;
            rem <= 4'd0;
            quo <= 8'd0;
            cnt <= 3'd0;
            if (y == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
              q     <= 8'hFF;
              r     <= x[3:0];
              dz    <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_8b4b.sv
// Directed bench for divider_8b4b: latency, results, divide-by-zero, back-to-back,
// ignored starts, reset abort and a full sweep of every (x, y) pair.
module tb_divider_8b4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic [3:0] y;
  logic [7:0] q;
  logic [3:0] r;
  logic       dz;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_8b4b dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .q(q), .r(r), .dz(dz), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Launch one operation and wait for done. lat counts negedges after the
  // acceptance edge up to the done cycle; bsy counts busy cycles. Bounded at 40.
  task automatic run_op(input logic [7:0] xv, input logic [3:0] yv,
                        output int lat, output int bsy);
    @(negedge clk);
    x = xv; y = yv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bsy = 0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x = 8'd0; y = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({q, r, dz, busy, done} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got q=%0d r=%0d dz=%b busy=%b done=%b want all zero", q, r, dz, busy, done);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got %0d want 0", dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bsy;
    run_op(8'd200, 4'd7, lat, bsy);
    checks++;
    if (lat !== 9 || bsy !== 8) begin
      errors++;
      $display("FAIL basic_latency got lat=%0d busy=%0d want 9 and 8", lat, bsy);
    end
    checks++;
    if (q !== 8'd28 || r !== 4'd4 || dz !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got q=%0d r=%0d dz=%b want 28 4 0", q, r, dz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || q !== 8'd28 || r !== 4'd4 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL basic_hold got done=%b q=%0d r=%0d st=%0d want 0 28 4 0", done, q, r, dbg_state);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] xs [3] = '{8'd255, 8'd5, 8'd0};
    logic [3:0] ys [3] = '{4'd1, 4'd9, 4'd15};
    logic [7:0] qs [3] = '{8'd255, 8'd0, 8'd0};
    logic [3:0] rs [3] = '{4'd0, 4'd5, 4'd0};
    int lat, bsy;
    for (int i = 0; i < 3; i++) begin
      run_op(xs[i], ys[i], lat, bsy);
      checks++;
      if (lat !== 9 || q !== qs[i] || r !== rs[i] || dz !== 1'b0) begin
        errors++;
        $display("FAIL vector_%0d got lat=%0d q=%0d r=%0d dz=%b want 9 %0d %0d 0", i, lat, q, r, dz, qs[i], rs[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bsy;
    run_op(8'd13, 4'd0, lat, bsy);
    checks++;
    if (lat !== 1 || bsy !== 0) begin
      errors++;
      $display("FAIL dz_latency got lat=%0d busy=%0d want 1 0", lat, bsy);
    end
    checks++;
    if (q !== 8'hFF || r !== 4'hD || dz !== 1'b1) begin
      errors++;
      $display("FAIL dz_result got q=%h r=%h dz=%b want ff d 1", q, r, dz);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    x = 8'd100; y = 4'd3; start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 9 || q !== 8'd33 || r !== 4'd1) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d q=%0d r=%0d want 9 33 1", lat, q, r);
    end
    x = 8'd99; y = 4'd10;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || q !== 8'd33) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b done=%b q=%0d want 1 0 33", busy, done, q);
    end
    lat = 1;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    start = 1'b0;
    checks++;
    if (lat !== 9 || q !== 8'd9 || r !== 4'd9) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d q=%0d r=%0d want 9 9 9", lat, q, r);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    x = 8'd200; y = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == 4) begin x = 8'd17; y = 4'd2; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat !== 9 || q !== 8'd28 || r !== 4'd4) begin
      errors++;
      $display("FAIL ignore_start got lat=%0d q=%0d r=%0d want 9 28 4", lat, q, r);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL ignore_after got busy=%b st=%0d want 0 0", busy, dbg_state);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bsy, seen;
    @(negedge clk);
    x = 8'd50; y = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({q, r, dz, busy, done} !== 15'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL abort_state got q=%0d r=%0d dz=%b busy=%b done=%b st=%0d want zeros", q, r, dz, busy, done, dbg_state);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d pulses want 0", seen);
    end
    run_op(8'd77, 4'd5, lat, bsy);
    checks++;
    if (lat !== 9 || q !== 8'd15 || r !== 4'd2 || dz !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart got lat=%0d q=%0d r=%0d dz=%b want 9 15 2 0", lat, q, r, dz);
    end
  endtask

  task automatic test_sweep();
    int lat, bsy;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ed;
    logic [7:0] xv;
    logic [3:0] yv;
    for (int i = 0; i < 4096; i++) begin
      xv = 8'(i >> 4);
      yv = 4'(i);
      if (yv == 4'd0) begin
        eq = 8'hFF; er = xv[3:0]; ed = 1'b1;
      end else begin
        eq = xv / {4'd0, yv}; er = 4'(xv % {4'd0, yv}); ed = 1'b0;
      end
      run_op(xv, yv, lat, bsy);
      checks++;
      if (lat !== ((yv == 4'd0) ? 1 : 9) || q !== eq || r !== er || dz !== ed) begin
        errors++;
        $display("FAIL sweep x=%0d y=%0d got lat=%0d q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b", xv, yv, lat, q, r, dz, eq, er, ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_8b4b.md
DIVIDER_8B4B -- requirements
Module: divider_8b4b

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at an 8-bit dividend and a 4-bit divisor.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 x  input  8  unsigned dividend; sampled on an accepted start.
REQ-006 y  input  4  unsigned divisor; sampled on an accepted start.
REQ-007 q  output  8  unsigned quotient; registered.
REQ-008 r  output  4  unsigned remainder; registered.
REQ-009 dz  output  1  divide-by-zero flag for the current result; registered.
REQ-010 busy  output  1  high while state=RUN.
REQ-011 done  output  1  one-cycle pulse that marks q/r/dz as valid.

Function
REQ-012 The block SHALL be an unsigned restoring divider that computes x = q*y + r with r < y for every y != 0.
REQ-013 The block SHALL have three states:
  - IDLE: no operation in progress.
  - RUN: iterating, one quotient bit per cycle.
  - DONE: result just produced.
REQ-014 A start SHALL be accepted in IDLE or DONE (busy=0).
  - x and y are latched on the same edge.
  - With y != 0, the next state is RUN.
REQ-015 In RUN, iteration k (k=0..7) SHALL process dividend bit 7-k, MSB first:
  - Form a 5-bit partial remainder {rem[3:0], dividend bit}.
  - If it is >= {1'b0,y}, subtract y and shift a 1 into the quotient; otherwise shift a 0.
REQ-016 A 3-bit iteration counter SHALL move RUN to DONE after exactly 8 RUN cycles.
REQ-017 Latency: with the start accepted at edge E0, busy SHALL be high for the cycles after E0..E8. At E8, q, r and dz=0 are loaded and done is high for the single cycle after E8.
REQ-018 Divide by zero (y=0 at acceptance) SHALL skip RUN and go directly to DONE.
  - On the acceptance edge, load q=8'hFF, r=x[3:0], dz=1.
  - done is high for the single cycle after that edge.
REQ-019 DONE SHALL last one cycle, then go to IDLE unless a new start is accepted in that cycle.
REQ-020 A start accepted in DONE SHALL go to RUN (or DONE again if y=0), with done still pulsing in that cycle (back-to-back operation).
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022 Changes on x and y after acceptance SHALL NOT affect the result.
REQ-023 q, r and dz SHALL hold their last result until the next completion.
  - They are not cleared on start.
  - Internal working registers SHALL be separate from the output registers.
REQ-024 The remainder path SHALL never overflow: the partial remainder is at most 5 bits, and after a subtraction it is < y, so it fits in 4 bits.

Reset
REQ-025 While rst=1 on a clock edge, the next state SHALL be:
  - state=IDLE, iteration counter=0;
  - q=0, r=0, dz=0, busy=0, done=0.
REQ-026 rst SHALL take priority over start and over any in-flight operation.
  - An operation aborted by reset SHALL NOT produce a done pulse.
  - Its outputs SHALL remain at their reset values.
REQ-027 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-028 x=200, y=7, start for 1 cycle -> busy high for 8 cycles; done in the 9th cycle with q=28, r=4, dz=0.
REQ-029 x=255, y=1 -> q=255, r=0. Then x=5, y=9 -> q=0, r=5. Then x=0, y=15 -> q=0, r=0.
REQ-030 x=13, y=0 -> done in the cycle after acceptance; q=8'hFF, r=4'hD, dz=1; busy never asserted.
REQ-031 start held high continuously with x=100, y=3 then x=99, y=10 presented on the done cycle:
  - first done with q=33, r=1;
  - second operation accepted in that done cycle;
  - second done 9 cycles later with q=9, r=9.
REQ-032 Stimulus within one run:
  - start x=200, y=7;
  - at RUN cycle 4, toggle x/y and pulse start: the result is unchanged (q=28, r=4);
  - in a second run, assert rst at RUN cycle 5: no done, q=r=0, state IDLE, and the next start completes correctly.
REQ-033 Exhaustive sweep of all 4096 (x,y) pairs -> every result satisfies x == q*y + r with r < y for y != 0, and the y=0 rule for y=0.
